// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: turns each (SubAddrL, data) command into a
// three-byte I2C write. Optional NACK retry is built when CFG_RETRY_EN is defined.
module codec_cfg_sequencer #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         NUM_CMDS   = 32,
  parameter int         GAP_CYCLES = 16,
  parameter int         MAX_RETRY  = 3
) (
  input  logic       I2C_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] SubAddrL,
  input  logic [7:0] data,
  input  logic       Write,
  output logic       NewCom,
  output logic       byte_req,
  output logic [7:0] byte_tx,
  output logic       byte_start,
  output logic       byte_stop,
  input  logic       byte_done,
  input  logic       byte_nack,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [4:0] cmd_idx
);

  localparam int              GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [4:0]      IDX_LAST = 5'(NUM_CMDS - 1);
  localparam logic [7:0]      DEV_BYTE = {DEV_ADDR, 1'b0};

  if (NUM_CMDS < 2 || NUM_CMDS > 32 || GAP_CYCLES < 2 ||
      MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_cfg
    $error("codec_cfg_sequencer: parameter out of range");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_GAP,
    S_LOAD,
    S_DEV,
    S_SUB,
    S_DAT,
    S_NEXT,
    S_DONE,
    S_ERROR,
    S_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q;
  logic [4:0]       idx_q, idx_d;
  logic             req_q;
  logic [7:0]       sub_q;
  logic [7:0]       dat_q;

  logic in_byte_state;
  logic at_rest;
  logic start_ok;
  logic ack_evt;
  logic nack_evt;

  assign in_byte_state = (state_q == S_DEV) || (state_q == S_SUB) || (state_q == S_DAT);
  assign at_rest       = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign start_ok      = start && at_rest;
  // byte_done only counts while a request is actually outstanding
  assign ack_evt       = req_q && byte_done && !byte_nack;
  assign nack_evt      = req_q && byte_done && byte_nack;

`ifdef CFG_RETRY_EN
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);
  logic [2:0] retry_q, retry_d;

  always_ff @(posedge I2C_clk) begin
    if (reset) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  // ---- control registers
  always_ff @(posedge I2C_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= (state_q == S_GAP) ? gap_q + 1'b1 : '0;
      if (req_q && byte_done) begin
        req_q <= 1'b0;
      end else begin
        req_q <= in_byte_state;
      end
    end
  end

  // ---- command holding registers (data only, no reset)
  always_ff @(posedge I2C_clk) begin
    if (state_q == S_LOAD) begin
      sub_q <= SubAddrL;
      dat_q <= data;
    end
  end

  // ---- next state and outputs
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    NewCom     = 1'b0;
    byte_tx    = 8'h00;
    byte_start = 1'b0;
    byte_stop  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_GAP;
          idx_d   = '0;
        end
      end
      S_ERROR: begin
        // the external counter is not rewound; walk it forward to index 0
        if (start) begin
          state_d = (idx_q == '0) ? S_GAP : S_FLUSH;
        end
      end
      S_FLUSH: begin
        NewCom = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_GAP;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = Write ? S_DEV : S_NEXT;
      end
      S_DEV: begin
        byte_tx    = DEV_BYTE;
        byte_start = 1'b1;
        if (ack_evt) begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        byte_tx = sub_q;
        if (ack_evt) begin
          state_d = S_DAT;
        end
      end
      S_DAT: begin
        byte_tx   = dat_q;
        byte_stop = 1'b1;
        if (ack_evt) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        NewCom = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef CFG_RETRY_EN
    retry_d = retry_q;
    if (state_q == S_NEXT || start_ok) begin
      retry_d = '0;
    end
    if (nack_evt) begin
      if (retry_q == RETRY_MAX) begin
        state_d = S_ERROR;
      end else begin
        state_d = S_GAP;
        retry_d = retry_q + 3'd1;
      end
    end
`else
    if (nack_evt) begin
      state_d = S_ERROR;
    end
`endif
  end

  assign byte_req  = req_q;
  assign cmd_idx   = idx_q;
  assign busy      = !at_rest;
  assign cfg_done  = (state_q == S_DONE) && !start_ok;
  assign cfg_error = (state_q == S_ERROR) && !start_ok;

endmodule

// File: doc/codec_cfg_sequencer.md
# codec_cfg_sequencer

Sequencer that walks the codec command table and turns each 16-bit command (SubAddrL, data) into a three-byte I2C write: device address, sub-address, data. It sits between the command generator (5-bit command counter + decoder, advanced by NewCom) and the byte-level I2C master, all on the I2C clock domain. It also handles NACK retry, inter-command spacing and done/error reporting to the system.

## Interface
- DEV_ADDR, 7'h1A: 7-bit codec I2C address; first byte sent is {DEV_ADDR, 1'b0}
- NUM_CMDS, 32: commands per sequence; must equal the command counter modulus (2..32)
- GAP_CYCLES, 16: idle I2C_clk cycles between transactions (>=2)
- MAX_RETRY, 3: retries per command after NACK (1..7)

Ports:
- I2C_clk  in  1  sole clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a sequence from IDLE, DONE or ERROR; ignored otherwise
- SubAddrL  in  8  sub-address of the current command
- data  in  8  payload of the current command
- Write  in  1  current command is a real write; 0 = NOP, skipped without bus traffic
- NewCom  out  1  one-cycle pulse advancing the command counter
- byte_req  out  1  request to byte master; held until byte_done
- byte_tx  out  8  byte to send; stable while byte_req=1
- byte_start  out  1  master issues START before this byte
- byte_stop  out  1  master issues STOP after this byte
- byte_done  in  1  one-cycle pulse: byte finished
- byte_nack  in  1  valid with byte_done; 1 = slave NACK (master has already issued STOP)
- busy  out  1  sequence in progress
- cfg_done  out  1  all NUM_CMDS commands accepted
- cfg_error  out  1  a command exhausted its retries
- cmd_idx  out  5  index of the command being processed

## Operation
- States: IDLE, GAP, LOAD, DEV, SUB, DAT, NEXT, DONE, ERROR.
- IDLE: all outputs 0. start -> GAP; cmd_idx=0, retry count=0.
- GAP: count GAP_CYCLES cycles -> LOAD.
- LOAD: latch SubAddrL/data into holding registers. If Write=0 -> NEXT. Else -> DEV.
- DEV: byte_tx={DEV_ADDR,0}, byte_start=1. SUB: byte_tx=sub-address. DAT: byte_tx=data, byte_stop=1.
- In DEV, SUB and DAT, byte_req stays high until byte_done.
  - done with nack=0 -> advance to the next byte state, or from DAT -> NEXT.
  - done with nack=1 -> retry handling (Configuration).
- NEXT: pulse NewCom; cmd_idx+1; retry count=0.
  - If this was command NUM_CMDS-1 -> DONE; cmd_idx wraps to 0.
  - Else -> GAP.
- DONE: cfg_done=1, busy=0; start -> new sequence.
- ERROR: cfg_error=1, busy=0; cmd_idx frozen at the failing command; start -> new sequence.
  - Restarting after error: the counter is not rewound. The sequencer first issues NewCom pulses, one per cycle, with no bus traffic, until cmd_idx wraps to 0, then enters GAP.
- busy=1 in every state except IDLE, DONE and ERROR.
- cfg_done and cfg_error are cleared in the cycle start is accepted.

## Timing
- Reset: sequencer goes to IDLE. All outputs 0 and all counters 0 the cycle after reset is sampled high.
- Reset mid-transaction: byte_req drops immediately. The byte master is reset by the same signal.
- byte_req rises 1 cycle after entering DEV, SUB or DAT. It falls the cycle after byte_done.
- byte_done arriving while byte_req=0 is ignored.
- Adjacent bytes: at least one cycle with byte_req low between them.
- NewCom is exactly 1 cycle wide.
- The command inputs are sampled in LOAD, at least GAP_CYCLES cycles after the preceding NewCom. The counter/decoder latency must be less than GAP_CYCLES.
- start while busy=1 is ignored.
- start in the same cycle as reset: reset wins.
- Minimum sequence length: NUM_CMDS*(GAP_CYCLES+2) cycles plus byte-master time.

## Configuration
- CFG_RETRY_EN defined: NACK returns to GAP and retries the same command without NewCom. The retry count increments per NACK. A NACK when count==MAX_RETRY -> ERROR.
- CFG_RETRY_EN undefined: any NACK goes directly to ERROR. The retry counter is not built.

## Test plan
- Reset, start, byte master always ACKs, all Write=1, NUM_CMDS=32, DEV_ADDR=7'h1A:
  - 96 byte transfers in the order 8'h34, SubAddrL, data.
  - byte_start only on 8'h34; byte_stop only on data.
  - 32 NewCom pulses; cfg_done=1; cmd_idx=0.
- Command 5 has Write=0: no bus bytes for index 5; NewCom is still pulsed; totals are 93 bytes and 32 NewCom.
- CFG_RETRY_EN, NACK on the SUB byte of command 3 twice, then ACK:
  - Command 3 is sent 3 times.
  - No NewCom between attempts.
  - cfg_done=1 at the end.
- CFG_RETRY_EN, MAX_RETRY=3, command 7 always NACKs:
  - 4 attempts, then cfg_error=1, cmd_idx=7, busy=0.
  - A following start produces 25 back-to-back NewCom pulses, then traffic resumes at index 0.
- Reset asserted while byte_req=1 in DAT: next cycle all outputs 0, state IDLE. A later start restarts at command 0.
- start pulsed during busy: no effect on state, cmd_idx or the byte sequence.
